// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the core.
// The master (core/bench) drives opcode and memory ready; the slave drives all controls.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic             imemReady;
    logic             dmemReady;
    logic             imemReq;
    logic             irWrite;
    logic             pcWrite;
    logic             branch;
    logic             memRead;
    logic             memToReg;
    logic [1:0]       ALUOp;
    logic             memWrite;
    logic             ALUSrc;
    logic             regWrite;
    logic             memErr;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;

    modport master (
        output opcode, imemReady, dmemReady,
        input  imemReq, irWrite, pcWrite, branch, memRead, memToReg, ALUOp,
               memWrite, ALUSrc, regWrite, memErr, instret, state
    );

    modport slave (
        input  opcode, imemReady, dmemReady,
        output imemReq, irWrite, pcWrite, branch, memRead, memToReg, ALUOp,
               memWrite, ALUSrc, regWrite, memErr, instret, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// retired-instruction counter and data-memory timeout. Define CONTROL_TRAP_EN to trap unknown opcodes.
module multicycle_control #(
    parameter logic [6:0]  INST_R     = 7'b0110011,
    parameter logic [6:0]  INST_I_LD  = 7'b0000011,
    parameter logic [6:0]  INST_I_IMM = 7'b0010011,
    parameter logic [6:0]  INST_S     = 7'b0100011,
    parameter logic [6:0]  INST_B     = 7'b1100011,
    parameter logic [6:0]  INST_J     = 7'b1101111,
    parameter logic [6:0]  INST_U     = 7'b0110111,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_control_if.slave bus
);
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             is_ld, is_st;

    assign is_ld = (op_q == INST_I_LD);
    assign is_st = (op_q == INST_S);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            to_cnt_q  <= '0;
            mem_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            to_cnt_q  <= to_cnt_d;
            mem_err_q <= mem_err_d;
            instret_q <= instret_d;
        end
    end

    // Next state and state-qualified datapath controls
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        to_cnt_d     = to_cnt_q;
        mem_err_d    = mem_err_q;
        retire       = 1'b0;
        bus.imemReq  = 1'b0;
        bus.irWrite  = 1'b0;
        bus.pcWrite  = 1'b0;
        bus.branch   = 1'b0;
        bus.memRead  = 1'b0;
        bus.memToReg = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.memWrite = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.regWrite = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.imemReq = 1'b1;
                if (bus.imemReady) begin
                    bus.irWrite = 1'b1;
                    bus.pcWrite = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d    = bus.opcode;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    INST_R: begin
                        bus.ALUOp = 2'b10;
                        state_d   = S_WB;
                    end
                    INST_I_IMM, INST_U: begin
                        bus.ALUSrc = 1'b1;
                        state_d    = S_WB;
                    end
                    INST_I_LD, INST_S: begin
                        bus.ALUSrc = 1'b1;
                        state_d    = S_MEM;
                    end
                    INST_B: begin
                        bus.ALUOp   = 2'b10;
                        bus.branch  = 1'b1;
                        bus.pcWrite = 1'b1;
                        state_d     = S_FETCH;
                        retire      = 1'b1;
                    end
                    INST_J: begin
                        bus.branch  = 1'b1;
                        bus.pcWrite = 1'b1;
                        state_d     = S_WB;
                    end
                    default: begin
`ifdef CONTROL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            S_MEM: begin
                bus.ALUSrc   = 1'b1;
                bus.memRead  = is_ld;
                bus.memWrite = is_st;
                if (bus.dmemReady) begin
                    to_cnt_d = '0;
                    if (is_ld) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Abandon the access; the instruction does not retire
                    mem_err_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = S_FETCH;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WB: begin
                bus.regWrite = 1'b1;
                bus.memToReg = is_ld;
                state_d      = S_FETCH;
                retire       = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    assign bus.memErr  = mem_err_q;
    assign bus.instret = instret_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: randomized memory latencies against a per-instruction trace model.
module tb_multicycle_control;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_U   = 7'b0110111;
    localparam int N_DONE = 0, N_MEM = 1, N_WB = 2, N_TRAP = 3, N_NONE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus();
    multicycle_control #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    // ctl = {state[3], imemReq, irWrite, pcWrite, branch, memRead, memToReg, ALUOp[2], memWrite, ALUSrc, regWrite, memErr}
    typedef struct { logic imr; logic dmr; logic [6:0] opc; logic [14:0] ctl; logic [31:0] ir; } cyc_t;
    typedef struct { logic [14:0] ctl; logic [31:0] ir; } obs_t;

    cyc_t        exp_q[$];
    obs_t        obs_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_instret;
    logic        m_memerr;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    function automatic logic [13:0] pk(input int st, input int req, input int irw, input int pcw,
                                       input int br, input int mr, input int m2r, input int aop,
                                       input int mw, input int asrc, input int rw);
        return {3'(st), 1'(req), 1'(irw), 1'(pcw), 1'(br), 1'(mr), 1'(m2r), 2'(aop),
                1'(mw), 1'(asrc), 1'(rw)};
    endfunction

    function automatic void push(input logic imr, input logic dmr, input logic [6:0] opc, input logic [13:0] c);
        cyc_t r;
        r.imr = imr; r.dmr = dmr; r.opc = opc;
        r.ctl = {c, m_memerr};
        r.ir  = m_instret;
        exp_q.push_back(r);
    endfunction

    // Reference: expected cycle-by-cycle trace of one instruction with wi fetch waits and wd data waits
    function automatic void build(input logic [6:0] op, input int wi, input int wd);
        int ld  = (op == OP_LD) ? 1 : 0;
        int st  = (op == OP_S) ? 1 : 0;
        int nxt = N_DONE;
        for (int i = 0; i < wi; i++) push(1'b0, rb(), ro(), pk(0,1,0,0,0,0,0,0,0,0,0));
        push(1'b1, rb(), ro(), pk(0,1,1,1,0,0,0,0,0,0,0));
        push(rb(), rb(), op, pk(1,0,0,0,0,0,0,0,0,0,0));
        case (op)
            OP_R:          begin push(rb(), rb(), ro(), pk(2,0,0,0,0,0,0,2,0,0,0)); nxt = N_WB; end
            OP_IMM, OP_U:  begin push(rb(), rb(), ro(), pk(2,0,0,0,0,0,0,0,0,1,0)); nxt = N_WB; end
            OP_LD, OP_S:   begin push(rb(), rb(), ro(), pk(2,0,0,0,0,0,0,0,0,1,0)); nxt = N_MEM; end
            OP_B:          begin push(rb(), rb(), ro(), pk(2,0,0,1,1,0,0,2,0,0,0)); nxt = N_DONE; end
            OP_J:          begin push(rb(), rb(), ro(), pk(2,0,0,1,1,0,0,0,0,0,0)); nxt = N_WB; end
            default: begin
                push(rb(), rb(), ro(), pk(2,0,0,0,0,0,0,0,0,0,0));
`ifdef CONTROL_TRAP_EN
                nxt = N_TRAP;
`else
                nxt = N_DONE;
`endif
            end
        endcase
        if (nxt == N_MEM) begin
            if (wd >= int'(TIMEOUT)) begin
                for (int i = 0; i < int'(TIMEOUT); i++) push(rb(), 1'b0, ro(), pk(3,0,0,0,0,ld,0,0,st,1,0));
                m_memerr = 1'b1;
                nxt = N_NONE;
            end else begin
                for (int i = 0; i < wd; i++) push(rb(), 1'b0, ro(), pk(3,0,0,0,0,ld,0,0,st,1,0));
                push(rb(), 1'b1, ro(), pk(3,0,0,0,0,ld,0,0,st,1,0));
                nxt = (ld == 1) ? N_WB : N_DONE;
            end
        end
        if (nxt == N_WB) begin
            push(rb(), rb(), ro(), pk(4,0,0,0,0,0,ld,0,0,0,1));
            nxt = N_DONE;
        end
        if (nxt == N_TRAP) begin
            for (int i = 0; i < 20; i++) push(rb(), rb(), ro(), pk(5,0,0,0,0,0,0,0,0,0,0));
        end
        if (nxt == N_DONE) m_instret = m_instret + 32'd1;
    endfunction

    // Applies the queued stimulus, one cycle per entry, sampling outputs 1 time unit after the falling edge
    task automatic run_trace();
        obs_t o;
        obs_q.delete();
        foreach (exp_q[i]) begin
            bus.opcode    = exp_q[i].opc;
            bus.imemReady = exp_q[i].imr;
            bus.dmemReady = exp_q[i].dmr;
            #1;
            o.ctl = {bus.state, bus.imemReq, bus.irWrite, bus.pcWrite, bus.branch, bus.memRead,
                     bus.memToReg, bus.ALUOp, bus.memWrite, bus.ALUSrc, bus.regWrite, bus.memErr};
            o.ir  = bus.instret;
            obs_q.push_back(o);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.opcode = 7'd0; bus.imemReady = 1'b0; bus.dmemReady = 1'b0;
        m_instret = 32'd0; m_memerr = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.state, bus.imemReq, bus.irWrite, bus.pcWrite, bus.branch, bus.memRead, bus.memToReg,
             bus.ALUOp, bus.memWrite, bus.ALUSrc, bus.regWrite, bus.memErr} !== {pk(0,1,0,0,0,0,0,0,0,0,0), 1'b0}) begin
            n_fail++; $display("FAIL reset_ctl: state=%0d imemReq=%b memErr=%b", bus.state, bus.imemReq, bus.memErr);
        end
        n_checks++;
        if (bus.instret !== 32'd0) begin
            n_fail++; $display("FAIL reset_instret: got %0d expected 0", bus.instret);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_r_type();
        int rw_cnt = 0;
        exp_q.delete();
        build(OP_R, 0, 0);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i].ctl !== exp_q[i].ctl || obs_q[i].ir !== exp_q[i].ir) begin
                n_fail++; $display("FAIL r_type cyc%0d: ctl=%b instret=%0d expected ctl=%b instret=%0d", i, obs_q[i].ctl, obs_q[i].ir, exp_q[i].ctl, exp_q[i].ir);
            end
            rw_cnt += int'(obs_q[i].ctl[1]);
        end
        n_checks++;
        if (rw_cnt !== 1) begin n_fail++; $display("FAIL r_type_regwrite_cycles: got %0d expected 1", rw_cnt); end
        n_checks++;
        if (bus.instret !== m_instret) begin n_fail++; $display("FAIL r_type_retire: got %0d expected %0d", bus.instret, m_instret); end
    endtask

    task automatic test_load();
        int mr_cnt = 0;
        exp_q.delete();
        build(OP_LD, 0, 3);
        build(OP_LD, int'($urandom_range(0, 3)), int'(TIMEOUT) - 1);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i].ctl !== exp_q[i].ctl || obs_q[i].ir !== exp_q[i].ir) begin
                n_fail++; $display("FAIL load cyc%0d: ctl=%b instret=%0d expected ctl=%b instret=%0d", i, obs_q[i].ctl, obs_q[i].ir, exp_q[i].ctl, exp_q[i].ir);
            end
            mr_cnt += int'(obs_q[i].ctl[7]);
        end
        n_checks++;
        if (mr_cnt !== 4 + int'(TIMEOUT)) begin n_fail++; $display("FAIL load_memread_cycles: got %0d expected %0d", mr_cnt, 4 + TIMEOUT); end
        n_checks++;
        if (bus.instret !== m_instret || bus.memErr !== 1'b0) begin
            n_fail++; $display("FAIL load_retire: instret=%0d memErr=%b expected %0d 0", bus.instret, bus.memErr, m_instret);
        end
    endtask

    task automatic test_store_timeout();
        int mw_cnt = 0;
        exp_q.delete();
        build(OP_S, 0, int'(TIMEOUT) + 4);
        build(OP_R, 1, 0);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i].ctl !== exp_q[i].ctl || obs_q[i].ir !== exp_q[i].ir) begin
                n_fail++; $display("FAIL store_timeout cyc%0d: ctl=%b instret=%0d expected ctl=%b instret=%0d", i, obs_q[i].ctl, obs_q[i].ir, exp_q[i].ctl, exp_q[i].ir);
            end
            mw_cnt += int'(obs_q[i].ctl[3]);
        end
        n_checks++;
        if (mw_cnt !== int'(TIMEOUT)) begin n_fail++; $display("FAIL store_memwrite_cycles: got %0d expected %0d", mw_cnt, TIMEOUT); end
        n_checks++;
        if (bus.instret !== m_instret || bus.memErr !== m_memerr) begin
            n_fail++; $display("FAIL store_sticky_err: instret=%0d memErr=%b expected %0d %b", bus.instret, bus.memErr, m_instret, m_memerr);
        end
    endtask

    task automatic test_branch();
        exp_q.delete();
        build(OP_B, 0, 0);
        build(OP_B, 2, 0);
        build(OP_J, 0, 0);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i].ctl !== exp_q[i].ctl || obs_q[i].ir !== exp_q[i].ir) begin
                n_fail++; $display("FAIL branch cyc%0d: ctl=%b instret=%0d expected ctl=%b instret=%0d", i, obs_q[i].ctl, obs_q[i].ir, exp_q[i].ctl, exp_q[i].ir);
            end
        end
        n_checks++;
        if (bus.instret !== m_instret) begin n_fail++; $display("FAIL branch_retire: got %0d expected %0d", bus.instret, m_instret); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7];
        ops = '{OP_R, OP_LD, OP_IMM, OP_S, OP_B, OP_J, OP_U};
        exp_q.delete();
        for (int n = 0; n < 30; n++)
            build(ops[$urandom_range(0, 6)], int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT + 2)));
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i].ctl !== exp_q[i].ctl || obs_q[i].ir !== exp_q[i].ir) begin
                n_fail++; $display("FAIL back_to_back cyc%0d: ctl=%b instret=%0d expected ctl=%b instret=%0d", i, obs_q[i].ctl, obs_q[i].ir, exp_q[i].ctl, exp_q[i].ir);
            end
            n_checks++;
            if ((obs_q[i].ctl[7] && obs_q[i].ctl[3]) || (obs_q[i].ctl[10] && obs_q[i].ctl[14:12] != 3'd0)) begin
                n_fail++; $display("FAIL exclusivity cyc%0d: ctl=%b", i, obs_q[i].ctl);
            end
        end
        n_checks++;
        if (bus.instret !== m_instret || bus.memErr !== m_memerr) begin
            n_fail++; $display("FAIL back_to_back_retire: instret=%0d memErr=%b expected %0d %b", bus.instret, bus.memErr, m_instret, m_memerr);
        end
    endtask

    task automatic test_reset_mid_mem();
        exp_q.delete();
        build(OP_LD, 0, int'(TIMEOUT) + 5);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i].ctl !== exp_q[i].ctl || obs_q[i].ir !== exp_q[i].ir) begin
                n_fail++; $display("FAIL reset_mid_mem cyc%0d: ctl=%b instret=%0d expected ctl=%b instret=%0d", i, obs_q[i].ctl, obs_q[i].ir, exp_q[i].ctl, exp_q[i].ir);
            end
        end
        bus.dmemReady = 1'b0;
        #1;
        n_checks++;
        if (bus.memRead !== 1'b1) begin n_fail++; $display("FAIL pre_reset_memread: got %b expected 1", bus.memRead); end
        rst = 1'b1;
        m_instret = 32'd0; m_memerr = 1'b0;
        #1;
        n_checks++;
        if ({bus.state, bus.memRead, bus.imemReq, bus.ALUSrc, bus.memErr} !== {3'd0, 1'b0, 1'b1, 1'b0, m_memerr} || bus.instret !== m_instret) begin
            n_fail++; $display("FAIL async_reset: state=%0d memRead=%b memErr=%b instret=%0d expected 0 0 0 0", bus.state, bus.memRead, bus.memErr, bus.instret);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unknown_op();
        logic [2:0] want_st;
`ifdef CONTROL_TRAP_EN
        want_st = 3'd5;
`else
        want_st = 3'd0;
`endif
        exp_q.delete();
        build(OP_R, 0, 0);
        build(7'b1111111, 0, 0);
        run_trace();
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i].ctl !== exp_q[i].ctl || obs_q[i].ir !== exp_q[i].ir) begin
                n_fail++; $display("FAIL unknown_op cyc%0d: ctl=%b instret=%0d expected ctl=%b instret=%0d", i, obs_q[i].ctl, obs_q[i].ir, exp_q[i].ctl, exp_q[i].ir);
            end
        end
        n_checks++;
        if (bus.instret !== m_instret || bus.state !== want_st) begin
            n_fail++; $display("FAIL unknown_op_end: instret=%0d state=%0d expected %0d %0d", bus.instret, bus.state, m_instret, want_st);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load();
        test_store_timeout();
        test_branch();
        test_back_to_back();
        test_reset_mid_mem();
        test_unknown_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
